// File: rtl/qpsk_mod_stream.sv
// qpsk_mod_stream: framed QPSK modulator. Takes FRAME_W-bit frames on a
// valid/ready handshake and sends them MSB-first as dibits, SPS samples per
// symbol. Each symbol is mixed onto a sine-LUT carrier to give a signed
// passband stream s = I*cos - Q*sin.
// Optional build macro QPSK_DIFF_EN: differential (DQPSK) mapping through a
// 2-bit phase state that is cleared at each frame load.
module qpsk_mod_stream #(
    parameter int FRAME_W   = 40,
    parameter int SPS       = 32,
    parameter int PHASE_W   = 16,
    parameter int PHASE_INC = 2048,
    parameter int LUT_AW    = 8,
    parameter int AMP_W     = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FRAME_W-1:0]      para_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [AMP_W:0]   qpsk,
    output logic                    out_valid,
    output logic                    sym_i,
    output logic                    sym_q,
    output logic                    sym_start,
    output logic                    frame_done
);

    localparam int  NSYM   = FRAME_W / 2;
    localparam int  LUT_N  = 1 << LUT_AW;
    localparam int  SC_W   = $clog2(SPS);
    localparam int  SYM_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int  STAGES = 3;
    localparam real PI     = 3.14159265358979323846;

    // Elaboration-time sine: fold into [-pi/2, pi/2], Taylor series, round half away from zero.
    function automatic int sin_val(input int k);
        real x, x2, term, acc;
        x = 2.0 * PI * real'(k) / real'(LUT_N);
        if (x > PI) x = x - 2.0 * PI;
        if (x > PI / 2.0) x = PI - x;
        else if (x < -PI / 2.0) x = -PI - x;
        x2   = x * x;
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x2 / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        acc = acc * real'((1 << (AMP_W - 1)) - 1);
        return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
    endfunction

    logic signed [AMP_W-1:0] sin_rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam int V = sin_val(k);
        assign sin_rom[k] = AMP_W'(V);
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic                 up;          // low on any reset edge, high afterwards
    logic [FRAME_W-1:0]   sreg;
    logic [PHASE_W-1:0]   phase;
    logic [SC_W-1:0]      sample_cnt;
    logic [SYM_W-1:0]     sym_cnt;

    logic                 sym_end, last_sym, accept, run;
    logic [1:0]           dibit;
    logic                 i0, q0;
    logic [LUT_AW-1:0]    addr_s;
`ifdef QPSK_DIFF_EN
    logic [1:0]           d_state;     // accumulated phase before current symbol
    logic [1:0]           d_inc, d_cur;
`endif

    // Frame control decode and symbol mapping for the sample being produced this cycle.
    always_comb begin
        sym_end  = (sample_cnt == SC_W'(SPS - 1));
        last_sym = (sym_cnt == SYM_W'(NSYM - 1));
        in_ready = up && ((state == IDLE) || (sym_end && last_sym));
        accept   = in_valid && in_ready;
        run      = (state == RUN);
        dibit    = sreg[FRAME_W-1 -: 2];
        addr_s   = phase[PHASE_W-1 -: LUT_AW];
`ifdef QPSK_DIFF_EN
        case (dibit)
            2'b00:   d_inc = 2'd0;
            2'b01:   d_inc = 2'd1;
            2'b11:   d_inc = 2'd2;
            default: d_inc = 2'd3;
        endcase
        d_cur = d_state + d_inc;
        i0    = run && (d_cur[1] ^ d_cur[0]);
        q0    = run && d_cur[1];
`else
        i0    = run && dibit[1];
        q0    = run && dibit[0];
`endif
    end

    // Frame FSM: load on handshake, step phase/sample/symbol counters while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            up         <= 1'b0;
            sreg       <= '0;
            phase      <= '0;
            sample_cnt <= '0;
            sym_cnt    <= '0;
`ifdef QPSK_DIFF_EN
            d_state    <= '0;
`endif
        end else begin
            up <= 1'b1;
            if (accept) begin
                // covers both IDLE loads and gapless reloads on the last sample
                state      <= RUN;
                sreg       <= para_in;
                phase      <= '0;
                sample_cnt <= '0;
                sym_cnt    <= '0;
`ifdef QPSK_DIFF_EN
                d_state    <= '0;
`endif
            end else if (run) begin
                phase <= phase + PHASE_W'(PHASE_INC);
                if (sym_end) begin
                    sample_cnt <= '0;
                    if (last_sym) begin
                        state   <= IDLE;
                        phase   <= '0;
                        sym_cnt <= '0;
                    end else begin
                        sym_cnt <= sym_cnt + SYM_W'(1);
                        sreg    <= sreg << 2;
`ifdef QPSK_DIFF_EN
                        d_state <= d_cur;
`endif
                    end
                end else begin
                    sample_cnt <= sample_cnt + SC_W'(1);
                end
            end
        end
    end

    logic [STAGES:1]         vld_pipe, ss_pipe, fd_pipe, i_pipe, q_pipe;
    logic [LUT_AW-1:0]       sin_a, cos_a;
    logic signed [AMP_W-1:0] sin_d, cos_d;
    logic signed [AMP_W:0]   cos_x, sin_x, ti, tq, sum;

    // Sign-apply and combine; |cos|+|sin| <= A*sqrt(2) so AMP_W+1 bits never overflow.
    always_comb begin
        cos_x = {cos_d[AMP_W-1], cos_d};
        sin_x = {sin_d[AMP_W-1], sin_d};
        ti    = i_pipe[2] ? -cos_x : cos_x;
        tq    = q_pipe[2] ? -sin_x : sin_x;
        sum   = ti - tq;
    end

    // Datapath: stage 1 LUT addresses, stage 2 LUT data + signs, stage 3 passband sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ss_pipe  <= '0;
            fd_pipe  <= '0;
            i_pipe   <= '0;
            q_pipe   <= '0;
            sin_a    <= '0;
            cos_a    <= '0;
            sin_d    <= '0;
            cos_d    <= '0;
            qpsk     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], run};
            ss_pipe  <= {ss_pipe[STAGES-1:1], run && (sample_cnt == '0)};
            fd_pipe  <= {fd_pipe[STAGES-1:1], run && sym_end && last_sym};
            i_pipe   <= {i_pipe[STAGES-1:1], i0};
            q_pipe   <= {q_pipe[STAGES-1:1], q0};
            sin_a    <= addr_s;
            cos_a    <= addr_s + LUT_AW'(LUT_N / 4);
            sin_d    <= sin_rom[sin_a];
            cos_d    <= sin_rom[cos_a];
            qpsk     <= vld_pipe[2] ? sum : '0;
        end
    end

    assign out_valid  = vld_pipe[STAGES];
    assign sym_start  = ss_pipe[STAGES];
    assign frame_done = fd_pipe[STAGES];
    assign sym_i      = i_pipe[STAGES];
    assign sym_q      = q_pipe[STAGES];

endmodule

// File: tb/tb_qpsk_mod_stream.sv
// Directed bench for qpsk_mod_stream: default 40-bit instance and a small
// 8-bit / SPS=4 instance sharing clock and reset.
module tb_qpsk_mod_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    logic [39:0]        p_para;
    logic               p_valid, p_ready, p_ov, p_si, p_sq, p_ss, p_fd;
    logic signed [14:0] p_qpsk;

    logic [7:0]         s_para;
    logic               s_valid, s_ready, s_ov, s_si, s_sq, s_ss, s_fd;
    logic signed [14:0] s_qpsk;

    qpsk_mod_stream u_big (
        .clk(clk), .rst_n(rst_n), .para_in(p_para), .in_valid(p_valid), .in_ready(p_ready),
        .qpsk(p_qpsk), .out_valid(p_ov), .sym_i(p_si), .sym_q(p_sq),
        .sym_start(p_ss), .frame_done(p_fd)
    );

    qpsk_mod_stream #(.FRAME_W(8), .SPS(4), .PHASE_INC(16384)) u_small (
        .clk(clk), .rst_n(rst_n), .para_in(s_para), .in_valid(s_valid), .in_ready(s_ready),
        .qpsk(s_qpsk), .out_valid(s_ov), .sym_i(s_si), .sym_q(s_sq),
        .sym_start(s_ss), .frame_done(s_fd)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a frame from a negedge and hold it until the handshake edge.
    task automatic p_send(input logic [39:0] f, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        p_para = f; p_valid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (p_ready) begin @(posedge clk); ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic s_send(input logic [7:0] f, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        s_para = f; s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (s_ready) begin @(posedge clk); ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    bit ok1, ok2;
    int k, first, last, nss, bad, nfd, fd_at, resid;
    logic [1:0] got_iq [4];
    logic [3:0] ei, eq;
    logic [7:0] sframe;

    initial begin
        rst_n = 1'b0; p_valid = 1'b0; p_para = '0; s_valid = 1'b0; s_para = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", p_ready, 0);
        chk("rst_valid", p_ov, 0);
        chk("rst_qpsk", p_qpsk, 0);
        chk("rst_iq", {p_si, p_sq}, 0);
        chk("rst_strobes", {p_ss, p_fd}, 0);
        chk("rst_s_ready", s_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", p_ready, 1);
        chk("rel_s_ready", s_ready, 1);

        // small instance: symbol signs and sample count
`ifdef QPSK_DIFF_EN
        sframe = 8'b01010101; ei = 4'b1100; eq = 4'b0110;
`else
        sframe = 8'b00011011; ei = 4'b0011; eq = 4'b0101;
`endif
        s_send(sframe, ok1);
        chk("s_hs", ok1, 1);
        @(negedge clk) s_valid = 1'b0;
        k = 0; nss = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (s_ov) begin
                if (s_ss && nss < 4) begin got_iq[nss] = {s_si, s_sq}; nss++; end
`ifdef QPSK_DIFF_EN
                if (k == 0) chk("s_q0", s_qpsk, -8191);
                if (k == 5) chk("s_q5", s_qpsk, 8191);
`else
                if (k == 5) chk("s_q5", s_qpsk, 8191);
                if (k == 8) chk("s_q8", s_qpsk, -8191);
`endif
                k++;
            end
        end
        chk("s_nvalid", k, 16);
        chk("s_nsym", nss, 4);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("s_sym%0d_i", s), got_iq[s][1], ei[3-s]);
            chk($sformatf("s_sym%0d_q", s), got_iq[s][0], eq[3-s]);
        end

`ifndef QPSK_DIFF_EN
        // single frame
        p_send(40'hFF171819FF, ok1);
        chk("t1_hs", ok1, 1);
        @(negedge clk) p_valid = 1'b0;
        k = 0; first = -1; last = -1; nss = 0; bad = 0; nfd = 0; fd_at = -1;
        for (int n = 1; n <= 700; n++) begin
            @(posedge clk); #1;
            if (p_ov) begin
                if (first < 0) first = n;
                last = n;
                if (k == 0) begin
                    chk("t1_s0", p_qpsk, -8191);
                    chk("t1_ss0", p_ss, 1);
                    chk("t1_iq0", {p_si, p_sq}, 3);
                end
                if (k == 144) chk("t1_sym4_s16", p_qpsk, -8191);
                if (k == 160) chk("t1_sym5_s0", p_qpsk, 8191);
                if (k == 168) chk("t1_sym5_s8", p_qpsk, 8191);
                if (k == 196) chk("t1_sym6_s4", p_qpsk, 11584);
                if (k == 232) chk("t1_sym7_s8", p_qpsk, 8191);
                if (p_ss) begin nss++; if (k % 32 != 0) bad++; end
                if (p_fd) begin nfd++; fd_at = k; end
                k++;
            end else if (p_ss || p_fd || p_qpsk != 0) begin
                bad++;
            end
        end
        chk("t1_latency", first, 3);
        chk("t1_nvalid", k, 640);
        chk("t1_contig", last - first + 1, 640);
        chk("t1_nsym", nss, 20);
        chk("t1_stray", bad, 0);
        chk("t1_nfd", nfd, 1);
        chk("t1_fd_at", fd_at, 639);
        chk("t1_idle_ready", p_ready, 1);

        // back-to-back frames with in_valid held
        k = 0; first = -1; last = -1; nfd = 0;
        fork
            begin
                p_send(40'h0, ok1);
                p_send(40'hFFFFFFFFFF, ok2);
                @(negedge clk) p_valid = 1'b0;
            end
            begin
                for (int n = 1; n <= 1500; n++) begin
                    @(posedge clk); #1;
                    if (p_ov) begin
                        if (first < 0) first = n;
                        last = n;
                        if (k == 0)   chk("t2_f1_s0", p_qpsk, 8191);
                        if (k == 16)  chk("t2_f1_s16", p_qpsk, -8191);
                        if (k == 640) begin
                            chk("t2_f2_s0", p_qpsk, -8191);
                            chk("t2_f2_ss", p_ss, 1);
                        end
                        if (k == 648) chk("t2_f2_s8", p_qpsk, 8191);
                        if (p_fd) nfd++;
                        k++;
                    end
                end
            end
        join
        chk("t2_hs1", ok1, 1);
        chk("t2_hs2", ok2, 1);
        chk("t2_nvalid", k, 1280);
        chk("t2_contig", last - first + 1, 1280);
        chk("t2_nfd", nfd, 2);
        chk("t2_idle_q", p_qpsk, 0);

        // reset during symbol 7
        p_send(40'hFF171819FF, ok1);
        chk("t3_hs", ok1, 1);
        @(negedge clk) p_valid = 1'b0;
        repeat (3 + 7 * 32 + 4) @(posedge clk);
        #1;
        chk("t3_pre_ov", p_ov, 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t3_rst_q", p_qpsk, 0);
        chk("t3_rst_ov", p_ov, 0);
        chk("t3_rst_ready", p_ready, 0);
        chk("t3_rst_si", p_si, 0);
        @(negedge clk) rst_n = 1'b1;
        resid = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (p_ov) resid++;
        end
        chk("t3_resid", resid, 0);
        chk("t3_ready", p_ready, 1);
        p_send(40'h0, ok1);
        chk("t3_hs2", ok1, 1);
        @(negedge clk) p_valid = 1'b0;
        k = 0; first = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (p_ov) begin
                if (first < 0) first = n;
                if (k == 0) chk("t3_s0", p_qpsk, 8191);
                if (k == 8) chk("t3_s8", p_qpsk, -8191);
                k++;
            end
        end
        chk("t3_latency", first, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
